// File: rtl/reg_file_32x32.sv
// 32-entry register file with two registered read ports, one write port,
// write-through bypass and a hard-wired zero register.
module reg_file_32x32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Wr_En,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [DATA_W-1:0] Wr_Data,
  input  logic              Rd_En,
  input  logic [ADDR_W-1:0] Rd_Addr_A,
  input  logic [ADDR_W-1:0] Rd_Addr_B,
  output logic [DATA_W-1:0] Rd_Data_A,
  output logic [DATA_W-1:0] Rd_Data_B,
  output logic              Rd_Valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_hit;
  logic [DATA_W-1:0] next_a;
  logic [DATA_W-1:0] next_b;

  // Writes to register 0 are dropped here, so it is never anything but zero.
  assign wr_hit = Wr_En && (Wr_Addr != '0);

  // Read mux: zero register first, then same-edge write bypass, then storage.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    next_a = regs[Rd_Addr_A];
    next_b = regs[Rd_Addr_B];
    if (Rd_Addr_A == '0)
      next_a = '0;
    else if (wr_hit && (Rd_Addr_A == Wr_Addr))
      next_a = Wr_Data;
    if (Rd_Addr_B == '0)
      next_b = '0;
    else if (wr_hit && (Rd_Addr_B == Wr_Addr))
      next_b = Wr_Data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      // NOTE: the whole array is cleared on reset, which forces flops rather
      // than a RAM macro; that is intended for a 32-entry register file.
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      Rd_Data_A <= '0;
      Rd_Data_B <= '0;
      Rd_Valid  <= 1'b0;
    end else begin
      if (wr_hit)
        regs[Wr_Addr] <= Wr_Data;
      Rd_Valid <= Rd_En;
      if (Rd_En) begin
        Rd_Data_A <= next_a;
        Rd_Data_B <= next_b;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Self-checking bench for reg_file_32x32: vector table, hand-written corner
// sequences and a scoreboard queue of expected read results.
module tb_reg_file_32x32;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Wr_En;
  logic [4:0]  Wr_Addr;
  logic [31:0] Wr_Data;
  logic        Rd_En;
  logic [4:0]  Rd_Addr_A;
  logic [4:0]  Rd_Addr_B;
  logic [31:0] Rd_Data_A;
  logic [31:0] Rd_Data_B;
  logic        Rd_Valid;

  reg_file_32x32 #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Wr_En     (Wr_En),
    .Wr_Addr   (Wr_Addr),
    .Wr_Data   (Wr_Data),
    .Rd_En     (Rd_En),
    .Rd_Addr_A (Rd_Addr_A),
    .Rd_Addr_B (Rd_Addr_B),
    .Rd_Data_A (Rd_Data_A),
    .Rd_Data_B (Rd_Data_B),
    .Rd_Valid  (Rd_Valid)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  exp_t        sb_q[$];
  logic [31:0] held_a;
  logic [31:0] held_b;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive after a falling edge, check outputs at the next
  // falling edge. Reads push their expectation; results pop it.
  task automatic step(input string name, input logic rst, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input logic re,
                      input logic [4:0] ra, input logic [4:0] rb,
                      input logic [31:0] ea, input logic [31:0] eb);
    exp_t e;
    Reset = rst; Wr_En = we; Wr_Addr = wa; Wr_Data = wd;
    Rd_En = re; Rd_Addr_A = ra; Rd_Addr_B = rb;
    if (rst && re) sb_q.push_back('{a: ea, b: eb});
    @(posedge Clk);
    @(negedge Clk);
    check({name, "_valid"}, {31'b0, Rd_Valid}, {31'b0, rst && re});
    if (!rst) begin
      held_a = '0;
      held_b = '0;
    end else if (re) begin
      e = sb_q.pop_front();
      held_a = e.a;
      held_b = e.b;
    end
    check({name, "_a"}, Rd_Data_A, held_a);
    check({name, "_b"}, Rd_Data_B, held_b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[13];

  initial begin
    held_a = '0;
    held_b = '0;
    Reset = 1'b0; Wr_En = 1'b0; Wr_Addr = '0; Wr_Data = '0;
    Rd_En = 1'b0; Rd_Addr_A = '0; Rd_Addr_B = '0;

    // Main vector table; address 3 was targeted during reset and must stay 0.
    vecs[0]  = '{1'b1, 5'd15, 32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd15, 5'd3,  32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd15, 5'd15, 32'h0,        32'h0};
    vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd15, 32'h0,        32'hDEADBEEF};
    vecs[5]  = '{1'b1, 5'd1,  32'h00000001, 1'b1, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[6]  = '{1'b1, 5'd1,  32'h12345678, 1'b1, 5'd1,  5'd1,  32'h12345678, 32'h12345678};
    vecs[7]  = '{1'b1, 5'd2,  32'h00000055, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[8]  = '{1'b1, 5'd2,  32'h000000AA, 1'b1, 5'd2,  5'd1,  32'h000000AA, 32'h12345678};
    vecs[9]  = '{1'b1, 5'd7,  32'h00000077, 1'b1, 5'd7,  5'd2,  32'h00000077, 32'h000000AA};
    vecs[10] = '{1'b1, 5'd9,  32'h00000099, 1'b1, 5'd15, 5'd9,  32'hDEADBEEF, 32'h00000099};
    vecs[11] = '{1'b0, 5'd4,  32'h00000044, 1'b1, 5'd4,  5'd4,  32'h0,        32'h0};
    vecs[12] = '{1'b1, 5'd5,  32'h00000005, 1'b1, 5'd4,  5'd1,  32'h0,        32'h12345678};

    @(negedge Clk);
    // Two reset cycles; the second also requests a write and a read.
    step("rst0", 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0,  32'h0, 32'h0);
    step("rst1", 1'b0, 1'b1, 5'd3, 32'h0000AAAA, 1'b1, 5'd3, 5'd3,  32'h0, 32'h0);
    step("post_rst_rd", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd31, 32'h0, 32'h0);

    for (int i = 0; i < 13; i++)
      step($sformatf("vec%0d", i), 1'b1, vecs[i].we, vecs[i].wa, vecs[i].wd,
           vecs[i].re, vecs[i].ra, vecs[i].rb, vecs[i].ea, vecs[i].eb);

    step("zero_reread", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 32'h0, 32'h0);

    // Reset pulse between edges must be ignored.
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
    step("glitch_rd", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 5'd7, 32'hDEADBEEF, 32'h00000077);

    // A read in flight followed by reset (with requests present) is dropped.
    step("inflight_rd", 1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd15, 5'd15, 32'hDEADBEEF, 32'hDEADBEEF);
    step("inflight_rst", 1'b0, 1'b1, 5'd15, 32'h11111111, 1'b1, 5'd15, 5'd15, 32'h0, 32'h0);
    step("after_rst_rd", 1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd15, 5'd2,  32'h0, 32'h0);

    // Fill every nonzero register, then stream reads of pairs (k, 31-k).
    for (int k = 1; k < 32; k++)
      step($sformatf("fill%0d", k), 1'b1, 1'b1, 5'(k), 32'(k) * 32'h01010101,
           1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    for (int k = 0; k < 32; k++)
      step($sformatf("pair%0d", k), 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'(k), 5'(31 - k),
           32'(k) * 32'h01010101, 32'(31 - k) * 32'h01010101);
    step("idle_end", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
